// File: rtl/axil_periph_arbiter_pkg.sv
// Shared types and constants for the two-master AXI-Lite peripheral arbiter.
package axil_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    WR_RESP = 3'd3,
    RD_ADDR = 3'd4,
    RD_DATA = 3'd5
  } arb_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axil_periph_arbiter_if.sv
// AXI-Lite bus bundle; master drives requests, slave drives readies/responses.
interface axi_lite_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          awvalid;
  logic          awready;
  logic [AW-1:0] awaddr;
  logic          wvalid;
  logic          wready;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] wstrb;
  logic          bvalid;
  logic          bready;
  logic [1:0]    bresp;
  logic          arvalid;
  logic          arready;
  logic [AW-1:0] araddr;
  logic          rvalid;
  logic          rready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axil_periph_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick: on a tie the requester that was
// not served last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt_onehot,
  output logic       idx
);

  // Select the winner from the request pair and the previous owner
  always_comb begin
    gnt_onehot = 2'b00;
    idx        = 1'b0;
    case (req)
      2'b01: begin
        gnt_onehot = 2'b01;
        idx        = 1'b0;
      end
      2'b10: begin
        gnt_onehot = 2'b10;
        idx        = 1'b1;
      end
      2'b11: begin
        gnt_onehot = last ? 2'b01 : 2'b10;
        idx        = ~last;
      end
      default: begin
        gnt_onehot = 2'b00;
        idx        = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/axil_periph_arbiter.sv
// Two-to-one AXI-Lite arbiter: one outstanding transaction at a time, owner
// chosen round-robin, all channels forwarded combinationally from the owner.
module axil_periph_arbiter
  import axil_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic       clk,
  input  logic       rst,
  axi_lite_if.slave  s0,
  axi_lite_if.slave  s1,
  axi_lite_if.master m,
  output logic [1:0] gnt,
  output logic       busy
);

  arb_state_t state_q, state_d;
  logic       g_q, g_d;
  logic       last_q, last_d;
  logic [1:0] gnt_q, gnt_d;

  logic [1:0] req;
  logic [1:0] pick_oh;
  logic       pick_idx;

  logic            own_awvalid, own_wvalid, own_bready, own_arvalid, own_rready;
  logic [AW-1:0]   own_awaddr, own_araddr;
  logic [DW-1:0]   own_wdata;
  logic [DW/8-1:0] own_wstrb;

  logic fwd_awready, fwd_wready, fwd_bvalid, fwd_arready, fwd_rvalid;

  assign req = {s1.awvalid | s1.arvalid, s0.awvalid | s0.arvalid};

  rr_arb2 u_rr (
    .req        (req),
    .last       (last_q),
    .gnt_onehot (pick_oh),
    .idx        (pick_idx)
  );

  assign own_awvalid = g_q ? s1.awvalid : s0.awvalid;
  assign own_awaddr  = g_q ? s1.awaddr  : s0.awaddr;
  assign own_wvalid  = g_q ? s1.wvalid  : s0.wvalid;
  assign own_wdata   = g_q ? s1.wdata   : s0.wdata;
  assign own_wstrb   = g_q ? s1.wstrb   : s0.wstrb;
  assign own_bready  = g_q ? s1.bready  : s0.bready;
  assign own_arvalid = g_q ? s1.arvalid : s0.arvalid;
  assign own_araddr  = g_q ? s1.araddr  : s0.araddr;
  assign own_rready  = g_q ? s1.rready  : s0.rready;

  // State, owner and fairness pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      g_q     <= 1'b0;
      last_q  <= 1'b1;
      gnt_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
    end
  end

  // Next-state decode and channel forwarding for the current owner
  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    m.awvalid   = 1'b0;
    m.awaddr    = own_awaddr;
    m.wvalid    = 1'b0;
    m.wdata     = own_wdata;
    m.wstrb     = own_wstrb;
    m.bready    = 1'b0;
    m.arvalid   = 1'b0;
    m.araddr    = own_araddr;
    m.rready    = 1'b0;
    fwd_awready = 1'b0;
    fwd_wready  = 1'b0;
    fwd_bvalid  = 1'b0;
    fwd_arready = 1'b0;
    fwd_rvalid  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d   = pick_oh;
          g_d     = pick_idx;
          // Write wins over read from the same master
          state_d = (pick_idx ? s1.awvalid : s0.awvalid) ? WR_ADDR : RD_ADDR;
        end
      end
      WR_ADDR: begin
        m.awvalid   = own_awvalid;
        fwd_awready = m.awready;
        if (own_awvalid && m.awready) state_d = WR_DATA;
      end
      WR_DATA: begin
        m.wvalid   = own_wvalid;
        fwd_wready = m.wready;
        if (own_wvalid && m.wready) state_d = WR_RESP;
      end
      WR_RESP: begin
        m.bready   = own_bready;
        fwd_bvalid = m.bvalid;
        if (m.bvalid && own_bready) begin
          last_d  = g_q;
          gnt_d   = 2'b00;
          state_d = IDLE;
        end
      end
      RD_ADDR: begin
        m.arvalid   = own_arvalid;
        fwd_arready = m.arready;
        if (own_arvalid && m.arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        m.rready   = own_rready;
        fwd_rvalid = m.rvalid;
        if (m.rvalid && own_rready) begin
          last_d  = g_q;
          gnt_d   = 2'b00;
          state_d = IDLE;
        end
      end
      default: begin
        gnt_d   = 2'b00;
        state_d = IDLE;
      end
    endcase
  end

  assign s0.awready = fwd_awready & ~g_q;
  assign s1.awready = fwd_awready &  g_q;
  assign s0.wready  = fwd_wready  & ~g_q;
  assign s1.wready  = fwd_wready  &  g_q;
  assign s0.bvalid  = fwd_bvalid  & ~g_q;
  assign s1.bvalid  = fwd_bvalid  &  g_q;
  assign s0.arready = fwd_arready & ~g_q;
  assign s1.arready = fwd_arready &  g_q;
  assign s0.rvalid  = fwd_rvalid  & ~g_q;
  assign s1.rvalid  = fwd_rvalid  &  g_q;

  assign s0.bresp = m.bresp;
  assign s1.bresp = m.bresp;
  assign s0.rdata = m.rdata;
  assign s1.rdata = m.rdata;
  assign s0.rresp = m.rresp;
  assign s1.rresp = m.rresp;

  assign gnt  = gnt_q;
  assign busy = (state_q != IDLE);

endmodule
